// File: rtl/rxn_capture_ctrl_pkg.sv
// Shared types for the receiver-node capture controller: sample formats,
// capture FSM state codes and the FIFO entry layout.
package rxn_capture_ctrl_pkg;

  localparam int TIME_W  = 32;
  localparam int VALUE_W = 16;

  typedef logic        [TIME_W-1:0]  TIME_FORMAT;
  typedef logic signed [VALUE_W-1:0] FILTER_OUT_FORMAT;

  // Codes are visible on the logger status probe, keep them stable.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_ARMED   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } capture_state_t;

  // 'time' is a reserved word, so the timestamp field is named ts.
  typedef struct packed {
    TIME_FORMAT       ts;
    FILTER_OUT_FORMAT value;
  } capture_entry_t;

  localparam int ENTRY_W = TIME_W + VALUE_W;

  // Signed level-crossing test between two consecutive accepted samples.
  function automatic logic crossed(input FILTER_OUT_FORMAT prev,
                                   input FILTER_OUT_FORMAT cur,
                                   input FILTER_OUT_FORMAT level,
                                   input logic             rising);
    if (rising) return (prev < level) && (level <= cur);
    return (prev > level) && (level >= cur);
  endfunction

endpackage

// File: rtl/rxn_capture_ctrl_fifo.sv
// Circular buffer holding the pre-trigger window plus in-flight post samples.
// push/pop on the same edge are both performed; drop_oldest retires the head
// alongside a push so the window slides without changing occupancy.
module capture_ring_fifo
  import rxn_capture_ctrl_pkg::*;
#(
  parameter int DEPTH = 17
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         drop_oldest,
  input  capture_entry_t               din,
  output capture_entry_t               dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  capture_entry_t   mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty  = (count == '0);
  assign do_pop = (pop || drop_oldest) && !empty;
  assign dout   = mem[head];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= din;
  end

  // Pointer and occupancy bookkeeping with synchronous flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)   tail <= ptr_next(tail);
      if (do_pop) head <= ptr_next(head);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Capacity guard: a push that neither pops nor drops must find room.
  always @(posedge clk) begin
    if (!rst && !flush) assert (!(push && !do_pop && count == CNT_W'(DEPTH)));
  end

endmodule

// File: rtl/rxn_capture_ctrl.sv
// Triggered capture controller feeding the receiver-node probe logger.
// Keeps a sliding pre-trigger window, detects a signed level crossing and
// streams window + post-trigger samples out one per cycle.
module rxn_capture_ctrl
  import rxn_capture_ctrl_pkg::*;
#(
  parameter int PRE_DEPTH  = 16,
  parameter int POST_COUNT = 256,
  parameter int DECIM      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  TIME_FORMAT       in_time,
  input  FILTER_OUT_FORMAT in_value,
  input  logic             arm,
  input  logic             abort,
  input  FILTER_OUT_FORMAT trig_level,
  input  logic             trig_rising,
  output logic             out_valid,
  output TIME_FORMAT       out_time,
  output FILTER_OUT_FORMAT out_value,
  output logic [2:0]       out_state,
  output logic             done
);

  // One extra slot holds the trigger sample, pushed without a drop.
  localparam int FIFO_DEPTH = PRE_DEPTH + 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int DEC_W      = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int POST_W     = $clog2(POST_COUNT + 1);

  capture_state_t   state;
  logic [DEC_W-1:0] dec_cnt;
  logic [POST_W-1:0] post_cnt;
  FILTER_OUT_FORMAT prev;
  logic             prev_valid;

  logic             accepted;
  logic             arm_take;
  logic             trig_hit;
  logic             fifo_flush;
  logic             fifo_push;
  logic             fifo_drop;
  logic             fifo_pop;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  capture_entry_t   fifo_din;
  capture_entry_t   fifo_dout;

  assign accepted = in_valid && (dec_cnt == '0);
  assign arm_take = arm && (state == ST_IDLE || state == ST_DONE);
  assign trig_hit = accepted && prev_valid && (state == ST_ARMED) &&
                    crossed(prev, in_value, trig_level, trig_rising);

  assign fifo_din   = '{ts: in_time, value: in_value};
  assign fifo_flush = abort || arm_take;
  assign fifo_push  = !abort && accepted &&
                      (state == ST_FILL || state == ST_ARMED || state == ST_CAPTURE);
  assign fifo_drop  = !abort && accepted && (state == ST_ARMED) && !trig_hit;
  assign fifo_pop   = !abort && !fifo_empty &&
                      (state == ST_CAPTURE || state == ST_DRAIN);

  assign out_state = state;
  assign done      = (state == ST_DONE);

  capture_ring_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush       (fifo_flush),
    .push        (fifo_push),
    .pop         (fifo_pop),
    .drop_oldest (fifo_drop),
    .din         (fifo_din),
    .dout        (fifo_dout),
    .count       (fifo_count),
    .empty       (fifo_empty)
  );

  // Capture FSM, decimation counter, trigger history and registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      dec_cnt    <= '0;
      post_cnt   <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_time   <= '0;
      out_value  <= '0;
    end else begin
      if (abort || arm_take) dec_cnt <= '0;
      else if (in_valid)
        dec_cnt <= (dec_cnt == DEC_W'(DECIM - 1)) ? '0 : dec_cnt + DEC_W'(1);

      // Output holds its last sample while out_valid is low.
      out_valid <= fifo_pop;
      if (fifo_pop) begin
        out_time  <= fifo_dout.ts;
        out_value <= fifo_dout.value;
      end

      if (abort) begin
        state      <= ST_IDLE;
        prev_valid <= 1'b0;
        post_cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (arm) begin
              state      <= ST_FILL;
              prev_valid <= 1'b0;
            end
          end
          ST_FILL: begin
            if (accepted) begin
              prev       <= in_value;
              prev_valid <= 1'b1;
              if (fifo_count == CNT_W'(PRE_DEPTH - 1)) state <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (accepted) begin
              prev       <= in_value;
              prev_valid <= 1'b1;
              if (trig_hit) begin
                post_cnt <= POST_W'(1);
                state    <= (POST_COUNT == 1) ? ST_DRAIN : ST_CAPTURE;
              end
            end
          end
          ST_CAPTURE: begin
            if (accepted) begin
              post_cnt <= post_cnt + POST_W'(1);
              if (post_cnt == POST_W'(POST_COUNT - 1)) state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (fifo_empty && !out_valid) state <= ST_DONE;
          end
          ST_DONE: begin
            if (arm) begin
              state      <= ST_FILL;
              prev_valid <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
